// File: rtl/alu_div_if.sv
// Operand, control and result bundle of the alu_div iterative divider.
interface alu_div_if #(
  parameter int data_wl = 16
);
  logic [data_wl-1:0] a_in;
  logic [data_wl-1:0] b_in;
  logic               signd;
  logic               ld;
  logic [data_wl-1:0] p_out;
  logic               valid;
  logic               rem_sel;
  logic               z_flag;
  logic               s_flag;
  logic               dz_flag;

  modport master (
    output a_in, b_in, signd, ld,
    input  p_out, valid, rem_sel, z_flag, s_flag, dz_flag
  );

  modport slave (
    input  a_in, b_in, signd, ld,
    output p_out, valid, rem_sel, z_flag, s_flag, dz_flag
  );
endinterface

// File: rtl/alu_div.sv
// Iterative restoring divider: one quotient bit per clock, then quotient and remainder on p_out.
// Optional feature macro ALU_DIV_DZ_BYPASS_EN: a zero divisor skips the iteration phase.
module alu_div #(
  parameter int data_wl = 16
) (
  input logic       clk,
  input logic       a_reset,
  alu_div_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(data_wl + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(data_wl);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [data_wl-1:0] ONE      = data_wl'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    QUOT,
    REM
  } state_t;

  state_t             state;
  logic [data_wl-1:0] a_raw;    // dividend as captured, returned on divide-by-zero
  logic [data_wl-1:0] dvd;      // dividend magnitude, shifts left into quotient bits
  logic [data_wl-1:0] dvs;      // divisor magnitude
  logic [data_wl:0]   prem;     // partial remainder
  logic [data_wl-1:0] rem_res;  // signed-corrected remainder held for the REM cycle
  logic [CNT_W-1:0]   cnt;
  logic               signd_r;
  logic               a_neg;
  logic               q_neg;
  logic               dz;

  logic [data_wl-1:0] p_out_q;
  logic               valid_q;
  logic               rem_sel_q;
  logic               z_flag_q;
  logic               s_flag_q;
  logic               dz_flag_q;

  function automatic logic [data_wl-1:0] neg(input logic [data_wl-1:0] x);
    return ~x + ONE;
  endfunction

  function automatic logic [data_wl-1:0] mag(input logic [data_wl-1:0] x, input logic s);
    return (s && x[data_wl-1]) ? neg(x) : x;
  endfunction

  function automatic logic is_neg(input logic [data_wl-1:0] x, input logic s);
    return s & x[data_wl-1];
  endfunction

  // One restoring step: shift the next dividend bit in, trial-subtract, keep or restore.
  logic [data_wl:0]   shifted;
  logic [data_wl:0]   diff;
  logic               fits;
  logic [data_wl:0]   prem_nxt;
  logic [data_wl-1:0] dvd_nxt;

  always_comb begin
    shifted  = (data_wl+1)'({prem, dvd[data_wl-1]});
    fits     = (shifted >= {1'b0, dvs});
    diff     = shifted - {1'b0, dvs};
    prem_nxt = fits ? diff : shifted;
    dvd_nxt  = {dvd[data_wl-2:0], fits};
  end

  logic [data_wl-1:0] rem_mag;
  logic [data_wl-1:0] quot_fin;
  logic [data_wl-1:0] rem_fin;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rem_mag  = data_wl'(prem);
    quot_fin = dvd;
    rem_fin  = rem_mag;
    if (dz) begin
      quot_fin = '1;
      rem_fin  = a_raw;
    end else begin
      if (q_neg) quot_fin = neg(dvd);
      if (a_neg) rem_fin  = neg(rem_mag);
    end
  end

  always_ff @(posedge clk or posedge a_reset) begin
    // NOTE: datapath registers are reset too, so an aborted divide leaves no residue.
    if (a_reset) begin
      state     <= IDLE;
      a_raw     <= '0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      rem_res   <= '0;
      cnt       <= '0;
      signd_r   <= 1'b0;
      a_neg     <= 1'b0;
      q_neg     <= 1'b0;
      dz        <= 1'b0;
      p_out_q   <= '0;
      valid_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      z_flag_q  <= 1'b0;
      s_flag_q  <= 1'b0;
      dz_flag_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (bus.ld) begin
            a_raw   <= bus.a_in;
            dvd     <= mag(bus.a_in, bus.signd);
            dvs     <= mag(bus.b_in, bus.signd);
            prem    <= '0;
            signd_r <= bus.signd;
            a_neg   <= is_neg(bus.a_in, bus.signd);
            q_neg   <= is_neg(bus.a_in, bus.signd) ^ is_neg(bus.b_in, bus.signd);
            dz      <= (bus.b_in == '0);
`ifdef ALU_DIV_DZ_BYPASS_EN
            // Preloading the terminal count makes the next edge publish the quotient.
            cnt     <= (bus.b_in == '0) ? CNT_LAST : '0;
`else
            cnt     <= '0;
`endif
            state   <= DIV;
          end
        end

        DIV: begin
          if (cnt == CNT_LAST) begin
            // All quotient bits are in; sign-correct and publish on the following cycle.
            p_out_q   <= quot_fin;
            valid_q   <= 1'b1;
            rem_sel_q <= 1'b0;
            z_flag_q  <= (quot_fin == '0);
            s_flag_q  <= signd_r & quot_fin[data_wl-1];
            dz_flag_q <= dz;
            rem_res   <= rem_fin;
            state     <= QUOT;
          end else begin
            prem <= prem_nxt;
            dvd  <= dvd_nxt;
            cnt  <= cnt + CNT_ONE;
          end
        end

        QUOT: begin
          p_out_q   <= rem_res;
          rem_sel_q <= 1'b1;
          z_flag_q  <= (rem_res == '0);
          s_flag_q  <= signd_r & rem_res[data_wl-1];
          state     <= REM;
        end

        REM: begin
          p_out_q   <= '0;
          valid_q   <= 1'b0;
          rem_sel_q <= 1'b0;
          z_flag_q  <= 1'b0;
          s_flag_q  <= 1'b0;
          dz_flag_q <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p_out   = p_out_q;
  assign bus.valid   = valid_q;
  assign bus.rem_sel = rem_sel_q;
  assign bus.z_flag  = z_flag_q;
  assign bus.s_flag  = s_flag_q;
  assign bus.dz_flag = dz_flag_q;

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 SHALL have parameter data_wl, default 16, operand and result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port a_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port a_in  input  data_wl  dividend.
REQ-005 SHALL have port b_in  input  data_wl  divisor.
REQ-006 SHALL have port signd  input  1  1 = two's-complement division, 0 = unsigned.
REQ-007 SHALL have port ld  input  1  start request.
REQ-008 SHALL have port p_out  output  data_wl  quotient in the first valid cycle, remainder in the second.
REQ-009 SHALL have port valid  output  1  p_out holds a result.
REQ-010 SHALL have port rem_sel  output  1  0 = p_out is quotient, 1 = p_out is remainder; meaningful only while valid=1.
REQ-011 SHALL have port z_flag  output  1  current p_out is zero.
REQ-012 SHALL have port s_flag  output  1  current p_out is negative (signed mode only).
REQ-013 SHALL have port dz_flag  output  1  divisor was zero.

Function
REQ-014 SHALL implement states IDLE, DIV, QUOT, REM; all outputs 0 in IDLE and DIV.
REQ-015 In IDLE, ld=1 at a clock edge SHALL capture a_in, b_in and signd, clear the counter, and move to DIV.
REQ-016 ld SHALL be ignored outside IDLE; in-flight operation is not disturbed.
REQ-017 DIV SHALL run restoring division on operand magnitudes, one quotient bit per cycle, for exactly data_wl cycles, then move to QUOT.
REQ-018 Magnitude SHALL be the two's-complement negation when signd=1 and MSB=1; otherwise the raw value.
REQ-019 Partial remainder SHALL be data_wl+1 bits wide so that the trial subtract never loses a carry.
REQ-020 Quotient SHALL be negated when signd=1 and operand signs differ; remainder SHALL take the dividend's sign (truncating division).
REQ-021 Signed 0x8000/0xFFFF (data_wl=16) SHALL return quotient 0x8000, remainder 0, with no error flag.
REQ-022 Divisor 0 SHALL return quotient all-ones, remainder = captured dividend, and dz_flag=1 in QUOT and REM, regardless of signd.
REQ-023 QUOT SHALL last one cycle: valid=1, rem_sel=0, p_out=quotient; next state REM.
REQ-024 REM SHALL last one cycle: valid=1, rem_sel=1, p_out=remainder; next state IDLE.
REQ-025 During valid cycles, z_flag SHALL be (p_out==0) and s_flag SHALL be signd_captured AND p_out MSB.
REQ-026 Latency SHALL be: ld edge k, quotient valid after edge k+data_wl+1, remainder after edge k+data_wl+2.
REQ-027 A new ld SHALL be accepted no earlier than the edge that returns the block to IDLE, plus one.

Reset
REQ-028 a_reset=1 SHALL immediately force IDLE and clear all operand, partial-remainder and counter registers, forcing every output to 0, including mid-DIV.
REQ-029 After a_reset deasserts, the first ld SHALL start a fresh operation with no residue of the aborted one.

Configuration
REQ-030 Macro ALU_DIV_DZ_BYPASS_EN defined: divisor 0 detected at capture SHALL skip DIV and go straight to QUOT (quotient valid after edge k+1).
REQ-031 Macro ALU_DIV_DZ_BYPASS_EN undefined: divisor 0 SHALL run the full data_wl DIV cycles; results and flags SHALL equal REQ-022 and latency SHALL equal REQ-026.

Verification
REQ-032 Unsigned 100/7 (0x0064/0x0007, signd=0) -> quotient 0x000E, then remainder 0x0002, valid 2 cycles, latency 17/18.
REQ-033 Signed -7/2 (0xFFF9/0x0002) -> quotient 0xFFFD with s_flag=1, then remainder 0xFFFF with s_flag=1.
REQ-034 0x1234/0x0000 -> quotient 0xFFFF, remainder 0x1234, dz_flag=1; quotient after edge k+1 with the macro, after edge k+17 without.
REQ-035 Signed 0x8000/0xFFFF -> quotient 0x8000 (s_flag=1), remainder 0x0000 (z_flag=1); and 0/5 -> quotient 0 with z_flag=1.
REQ-036 Assert a_reset at DIV cycle 8 -> all outputs 0 immediately; a new 100/7 after release -> 0x000E/0x0002 at standard latency.
REQ-037 Pulse ld with 9/3 during DIV of 100/7 -> 100/7 results unchanged; 9/3 not executed.
